// File: rtl/glacier_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// glacier_pkg: shared geometry, coordinate type and scheduler states. rev 1.0
// ---------------------------------------------------------------------------
package glacier_pkg;
  localparam int SCREEN_H    = 720;
  localparam int SPRITE_SIZE = 128;
  localparam int SPAWN_X     = 276;
  localparam int SPAWN_Y     = 96;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    SPAWN  = 2'd2
  } sched_state_t;

  typedef logic [15:0] coord_t;
endpackage
`default_nettype wire

// File: rtl/hit_priority_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hit_priority_arbiter: registered lowest-index-wins encoder. rev 1.0
// ---------------------------------------------------------------------------
module hit_priority_arbiter #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_req,
  output logic         o_valid,
  output logic [2:0]   o_idx
);
  logic       win_valid;
  logic [2:0] win_idx;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = 3'd0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[k]) begin
        win_valid = 1'b1;
        win_idx   = 3'(k);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_idx   <= 3'd0;
    end else begin
      o_valid <= win_valid;
      o_idx   <= win_idx;
    end
  end
endmodule
`default_nettype wire

// File: rtl/glacier_spawn_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// glacier_spawn_scheduler: per-frame slot motion/spawn FSM + hit arbiter. rev 1.0
// ---------------------------------------------------------------------------
module glacier_spawn_scheduler
  import glacier_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int SPAWN_INTERVAL = 60,
  parameter int SPAWN_X        = glacier_pkg::SPAWN_X,
  parameter int SPAWN_Y        = glacier_pkg::SPAWN_Y,
  parameter int SPRITE_SIZE    = glacier_pkg::SPRITE_SIZE,
  parameter int SCREEN_H       = glacier_pkg::SCREEN_H
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_v_sync,
  input  logic                    i_enable,
  input  logic [NUM_SLOTS-1:0]    i_hit,
  output logic [16*NUM_SLOTS-1:0] o_slot_x,
  output logic [16*NUM_SLOTS-1:0] o_slot_y,
  output logic [NUM_SLOTS-1:0]    o_slot_active,
  output logic                    o_sel_valid,
  output logic [2:0]              o_sel_slot,
  output logic                    o_spawn_drop,
  output logic                    o_busy
);
  localparam coord_t      RETIRE_Y   = 16'(SCREEN_H - SPRITE_SIZE);
  localparam logic [15:0] LAST_COUNT = 16'(SPAWN_INTERVAL - 1);
  localparam logic [2:0]  LAST_IDX   = 3'(NUM_SLOTS - 1);

  sched_state_t          state, state_nxt;
  logic [2:0]            idx;
  logic [15:0]           frame_cnt;
  logic                  vs_prev, pending, frame_edge;
  logic                  spawn_due, free_found;
  logic [2:0]            free_idx;
  logic [NUM_SLOTS-1:0]  active;
  logic [NUM_SLOTS-1:0]  hit_req;

  assign frame_edge = i_v_sync & ~vs_prev;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_enable && (frame_edge || pending)) state_nxt = UPDATE;
      UPDATE:  if (idx == LAST_IDX) state_nxt = SPAWN;
      SPAWN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Free slot is chosen after the update pass, so a slot retired this frame is reusable.
  always_comb begin
    free_found = 1'b0;
    free_idx   = 3'd0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (!active[k]) begin
        free_found = 1'b1;
        free_idx   = 3'(k);
      end
    end
  end

  assign spawn_due    = (state == SPAWN) && (frame_cnt == LAST_COUNT);
  assign o_spawn_drop = spawn_due & ~free_found;
  assign o_busy       = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      vs_prev   <= 1'b0;
      pending   <= 1'b0;
      idx       <= 3'd0;
      frame_cnt <= 16'd0;
    end else begin
      state   <= state_nxt;
      vs_prev <= i_v_sync;
      // In IDLE the flag is either consumed by a new pass or discarded while disabled.
      if (state == IDLE)   pending <= 1'b0;
      else if (frame_edge) pending <= 1'b1;
      if (state == UPDATE) idx <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
      else                 idx <= 3'd0;
      if (state == SPAWN)  frame_cnt <= spawn_due ? 16'd0 : frame_cnt + 16'd1;
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    coord_t x_q, y_q;
    logic   act_q, visit, retire, spawn_here;

    assign visit      = (state == UPDATE) && (idx == 3'(k)) && act_q;
    assign retire     = (x_q == 16'd0) || (y_q > RETIRE_Y);
    assign spawn_here = spawn_due && free_found && (free_idx == 3'(k));

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        act_q <= 1'b0;
        x_q   <= 16'(SPAWN_X);
        y_q   <= 16'(SPAWN_Y);
      end else if (spawn_here) begin
        act_q <= 1'b1;
        x_q   <= 16'(SPAWN_X);
        y_q   <= 16'(SPAWN_Y);
      end else if (visit) begin
        if (retire) begin
          act_q <= 1'b0;
        end else begin
          x_q <= x_q - 16'd1;
          y_q <= y_q + 16'd1;
        end
      end
    end

    assign active[k]             = act_q;
    assign o_slot_x[16*k +: 16]  = x_q;
    assign o_slot_y[16*k +: 16]  = y_q;
  end

  assign o_slot_active = active;
  assign hit_req       = i_hit & active;

  hit_priority_arbiter #(
    .N (NUM_SLOTS)
  ) u_arb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   (hit_req),
    .o_valid (o_sel_valid),
    .o_idx   (o_sel_slot)
  );
endmodule
`default_nettype wire

// File: tb/tb_glacier_spawn_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_glacier_spawn_scheduler: directed vectors for the glacier scheduler. rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_glacier_spawn_scheduler;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           v_sync = 1'b0;
  logic           enable = 1'b0;
  logic [N-1:0]   hit = '0;
  logic [16*N-1:0] slot_x, slot_y;
  logic [N-1:0]   slot_active;
  logic           sel_valid, spawn_drop, busy;
  logic [2:0]     sel_slot;

  int vectors     = 0;
  int miscompares = 0;
  int frames      = 0;

  always #5 clk = ~clk;

  glacier_spawn_scheduler #(
    .NUM_SLOTS      (N),
    .SPAWN_INTERVAL (60),
    .SPAWN_X        (276),
    .SPAWN_Y        (96),
    .SPRITE_SIZE    (128),
    .SCREEN_H       (720)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_v_sync      (v_sync),
    .i_enable      (enable),
    .i_hit         (hit),
    .o_slot_x      (slot_x),
    .o_slot_y      (slot_y),
    .o_slot_active (slot_active),
    .o_sel_valid   (sel_valid),
    .o_sel_slot    (sel_slot),
    .o_spawn_drop  (spawn_drop),
    .o_busy        (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sx(input int k);
    return slot_x[16*k +: 16];
  endfunction

  function automatic logic [15:0] sy(input int k);
    return slot_y[16*k +: 16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: a single-cycle v_sync pulse, then enough idle time for the pass.
  task automatic frame();
    tick(); v_sync = 1'b1;
    tick(); v_sync = 1'b0;
    repeat (6) tick();
    frames++;
  endtask

  task automatic run_to(input int target);
    while (frames < target) frame();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_active", slot_active, 4'b0000);
    chk("rst_x_all", slot_x, {4{16'd276}});
    chk("rst_y_all", slot_y, {4{16'd96}});
    chk("rst_sel_valid", sel_valid, 1'b0);
    chk("rst_sel_slot", sel_slot, 3'd0);
    chk("rst_drop", spawn_drop, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    enable = 1'b1;

    run_to(59);
    chk("pre_spawn_active", slot_active, 4'b0000);
    run_to(60);
    chk("spawn60_active", slot_active, 4'b0001);
    chk("spawn60_x0", sx(0), 16'd276);
    chk("spawn60_y0", sy(0), 16'd96);
    run_to(61);
    chk("move61_x0", sx(0), 16'd275);
    chk("move61_y0", sy(0), 16'd97);
    chk("move61_active", slot_active, 4'b0001);
    chk("move61_x1_idle", sx(1), 16'd276);

    hit = 4'b0001; tick();
    chk("arb_s0_valid", sel_valid, 1'b1);
    chk("arb_s0_slot", sel_slot, 3'd0);
    hit = 4'b1000; tick();
    chk("arb_inactive_valid", sel_valid, 1'b0);
    chk("arb_inactive_slot", sel_slot, 3'd0);
    hit = 4'b0000;

    run_to(180);
    chk("f180_active", slot_active, 4'b0111);
    hit = 4'b0110; tick();
    chk("arb_0110_valid", sel_valid, 1'b1);
    chk("arb_0110_slot", sel_slot, 3'd1);
    hit = 4'b0000;

    // Frame 300: all slots live when a spawn is due.
    run_to(299);
    tick(); v_sync = 1'b1;
    tick(); v_sync = 1'b0;
    chk("f300_busy_upd", busy, 1'b1);
    tick(); tick(); tick();
    chk("f300_drop_upd3", spawn_drop, 1'b0);
    tick();
    chk("f300_drop_spawn", spawn_drop, 1'b1);
    chk("f300_busy_spawn", busy, 1'b1);
    tick();
    chk("f300_drop_after", spawn_drop, 1'b0);
    chk("f300_busy_after", busy, 1'b0);
    chk("f300_active", slot_active, 4'b1111);
    chk("f300_x0", sx(0), 16'd36);
    chk("f300_x1", sx(1), 16'd96);
    chk("f300_y1", sy(1), 16'd276);
    repeat (3) tick();
    frames++;

    run_to(336);
    chk("f336_active0", slot_active[0], 1'b1);
    chk("f336_x0", sx(0), 16'd0);
    chk("f336_y0", sy(0), 16'd372);
    run_to(337);
    chk("f337_active", slot_active, 4'b1110);
    chk("f337_x0_held", sx(0), 16'd0);
    chk("f337_y0_held", sy(0), 16'd372);
    hit = 4'b0001; tick();
    chk("arb_dead0_valid", sel_valid, 1'b0);
    chk("arb_dead0_slot", sel_slot, 3'd0);
    hit = 4'b1001; tick();
    chk("arb_1001_slot", sel_slot, 3'd3);
    hit = 4'b0000;

    run_to(359);
    chk("f359_active", slot_active, 4'b1110);
    run_to(360);
    chk("f360_active", slot_active, 4'b1111);
    chk("f360_x0", sx(0), 16'd276);
    chk("f360_y0", sy(0), 16'd96);
    chk("f360_x1", sx(1), 16'd36);

    // Extra edges during a pass: one queued, the next dropped.
    tick(); v_sync = 1'b1;
    tick(); v_sync = 1'b0;
    tick(); v_sync = 1'b1;
    tick(); v_sync = 1'b0;
    tick(); v_sync = 1'b1;
    tick(); v_sync = 1'b0;
    tick();
    chk("pend_idle_busy", busy, 1'b0);
    chk("pend_idle_x0", sx(0), 16'd275);
    tick();
    chk("pend_pass_busy", busy, 1'b1);
    repeat (5) tick();
    chk("pend_done_busy", busy, 1'b0);
    chk("pend_x0", sx(0), 16'd274);
    chk("pend_y0", sy(0), 16'd98);
    tick();
    chk("pend_no_third", busy, 1'b0);
    frames += 2;

    enable = 1'b0;
    tick(); v_sync = 1'b1;
    tick(); v_sync = 1'b0;
    chk("dis_busy", busy, 1'b0);
    repeat (6) tick();
    chk("dis_x0", sx(0), 16'd274);
    enable = 1'b1;

    // Asynchronous reset while the pass is on slot 2.
    tick(); v_sync = 1'b1;
    tick(); v_sync = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("amid_active", slot_active, 4'b0000);
    chk("amid_x_all", slot_x, {4{16'd276}});
    chk("amid_y_all", slot_y, {4{16'd96}});
    chk("amid_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    frame();
    chk("post_rst_active", slot_active, 4'b0000);
    chk("post_rst_x_all", slot_x, {4{16'd276}});
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_sel", sel_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
